// File: rtl/sb_serializer.sv
// Parallel-to-serial sideband transmitter: sends a WIDTH-bit frame LSB first,
// then holds the line idle for GAP cycles before accepting the next frame.
module sb_serializer #(
  parameter int WIDTH   = 128,
  parameter int WIDTH_W = 8,
  parameter int GAP     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_data,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [WIDTH_W-1:0] LAST_BIT = WIDTH_W'(WIDTH - 1);
  localparam logic [WIDTH_W-1:0] LAST_GAP = WIDTH_W'((GAP > 0) ? GAP - 1 : 0);

  state_t             state_reg, state_next;
  logic [WIDTH_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic               out_data_reg, out_data_next;
  logic               out_valid_reg, out_valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      out_data_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // out_data/out_valid are registered one step ahead: bit 0 is loaded straight
  // from in_data at acceptance, later bits come from the residual shift register.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    out_data_next  = 1'b0;
    out_valid_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next     = ST_SEND;
          cnt_next       = '0;
          shift_next     = in_data >> 1;
          out_data_next  = in_data[0];
          out_valid_next = 1'b1;
        end
      end
      ST_SEND: begin
        if (cnt_reg == LAST_BIT) begin
          cnt_next   = '0;
          state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          cnt_next       = cnt_reg + WIDTH_W'(1);
          out_data_next  = shift_reg[0];
          out_valid_next = 1'b1;
          shift_next     = shift_reg >> 1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == LAST_GAP) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + WIDTH_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sb_serializer.sv
// Bench for sb_serializer: a GAP=32 instance and a GAP=0 instance, checked by
// a bit-collecting receiver model against the frames handed in.
module tb_sb_serializer;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data0 = '0, in_data1 = '0;
  logic         in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic         in_ready0, in_ready1, out_data0, out_data1, out_valid0, out_valid1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sb_serializer #(.WIDTH(W), .WIDTH_W(8), .GAP(32)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0));

  sb_serializer #(.WIDTH(W), .WIDTH_W(8), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input bit sel);
    return sel ? out_valid1 : out_valid0;
  endfunction

  function automatic logic od(input bit sel);
    return sel ? out_data1 : out_data0;
  endfunction

  function automatic logic [W-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_data(input bit sel, input logic [W-1:0] d);
    if (sel) in_data1 = d; else in_data0 = d;
  endtask

  // Receiver model: waits for out_valid, deserializes W bits LSB first,
  // optionally scrambles in_data while the frame is on the wire.
  task automatic receive(input bit sel, input logic [W-1:0] next_frame, input bit scramble,
                         input bit hold, output logic [W-1:0] word, output int start);
    int budget = 0;
    word = '0;
    while (ov(sel) !== 1'b1 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk("frame_start_in_time", W'(budget < 400), W'(1));
    start = cyc;
    for (int k = 0; k < W; k++) begin
      if (ov(sel) !== 1'b1) chk("valid_run", W'(ov(sel)), W'(1));
      word[k] = od(sel);
      if (k == 0 && !hold) begin
        if (sel) in_valid1 = 1'b0; else in_valid0 = 1'b0;
      end
      if (scramble) set_data(sel, rand_frame());
      if (k == W - 1) set_data(sel, next_frame);
      @(negedge clk);
    end
    chk("valid_drop_after_frame", W'(ov(sel)), W'(0));
  endtask

  task automatic wait_ready0();
    int budget = 0;
    while (in_ready0 !== 1'b1 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_in_time", W'(budget < 400), W'(1));
  endtask

  initial begin
    logic [W-1:0] f, a, b, c, d, e, g, rx;
    int t0, t1, rel;

    // Reset held: nothing ready, line idle.
    repeat (3) begin
      @(negedge clk);
      chk("reset_in_ready", W'(in_ready0), W'(0));
      chk("reset_out_valid", W'(out_valid0), W'(0));
    end
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", W'(in_ready0), W'(1));
    chk("post_reset_out_data", W'(out_data0), W'(0));
    chk("post_reset_ready_gap0", W'(in_ready1), W'(1));

    // Single fixed frame, then exactly 32 idle cycles.
    f = 128'h0000_0000_0001_8000_0000_0000_0000_0005;
    in_data0 = f;
    in_valid0 = 1'b1;
    receive(1'b0, f, 1'b0, 1'b0, rx, t0);
    chk("single_frame_bits", rx, f);
    chk("single_frame_bit_pattern", W'(rx[3:0]), W'(4'b0101));
    for (int gi = 1; gi < 32; gi++) begin
      chk("gap_out_valid", W'(out_valid0), W'(0));
      chk("gap_out_data", W'(out_data0), W'(0));
      chk("gap_in_ready", W'(in_ready0), W'(0));
      @(negedge clk);
    end
    chk("gap_in_ready_last", W'(in_ready0), W'(0));
    @(negedge clk);
    chk("ready_after_gap", W'(in_ready0), W'(1));

    // Back-to-back with in_valid held, in_data scrambled during SEND.
    a = rand_frame();
    b = rand_frame();
    in_data0 = a;
    in_valid0 = 1'b1;
    receive(1'b0, b, 1'b1, 1'b1, rx, t0);
    chk("b2b_frame_a", rx, a);
    receive(1'b0, b, 1'b0, 1'b0, rx, t1);
    chk("b2b_frame_b", rx, b);
    chk("b2b_spacing", W'(t1 - t0), W'(161));

    // GAP=0 instance: one idle cycle between frames.
    c = rand_frame();
    d = rand_frame();
    in_data1 = c;
    in_valid1 = 1'b1;
    receive(1'b1, d, 1'b1, 1'b1, rx, t0);
    chk("gap0_frame_c", rx, c);
    receive(1'b1, d, 1'b0, 1'b0, rx, t1);
    chk("gap0_frame_d", rx, d);
    chk("gap0_spacing", W'(t1 - t0), W'(129));

    // Reset pulsed at bit 40 of a frame.
    wait_ready0();
    e = rand_frame();
    in_data0 = e;
    in_valid0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (out_data0 !== e[k] || out_valid0 !== 1'b1)
        chk("pre_reset_bits", W'({out_valid0, out_data0}), W'({1'b1, e[k]}));
      @(negedge clk);
    end
    chk("bit40_before_reset", W'(out_data0), W'(e[40]));
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_reset_out_valid", W'(out_valid0), W'(0));
      chk("mid_reset_in_ready", W'(in_ready0), W'(0));
    end
    rst = 1'b0;
    g = rand_frame();
    in_data0 = g;
    rel = cyc;
    #1;
    chk("release_in_ready", W'(in_ready0), W'(1));
    receive(1'b0, g, 1'b0, 1'b0, rx, t0);
    chk("after_reset_frame", rx, g);
    chk("after_reset_latency", W'(t0 - rel), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
